// File: rtl/piano_key_reader_pkg.sv
// -----------------------------------------------------------------------------
// piano_key_reader_pkg
// Shared definitions for the piano key reader: the key-event byte layout, the
// field offsets of the CPU read word, default parameters and the event
// encoder used by the push arbiter.
// -----------------------------------------------------------------------------
package piano_key_reader_pkg;

  localparam int NUM_KEYS                = 8;

  // Key-event byte layout: [7] press(1)/release(0), [6:3] zero, [2:0] key index.
  localparam int PRESS_BIT               = 7;
  localparam int KEY_IDX_MSB             = 2;

  // CPU read word layout: [7:0] head event, [11:8] count, [12] overflow.
  localparam int COUNT_LSB               = 8;
  localparam int COUNT_W                 = 4;
  localparam int OVF_BIT                 = 12;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;
  localparam int DEFAULT_FIFO_DEPTH      = 8;

  typedef logic [7:0] key_event_t;

  function automatic key_event_t encode_event(input logic [KEY_IDX_MSB:0] key_idx,
                                              input logic                 pressed);
    key_event_t ev;
    ev                 = '0;
    ev[PRESS_BIT]      = pressed;
    ev[KEY_IDX_MSB:0]  = key_idx;
    return ev;
  endfunction

endpackage

// File: rtl/piano_key_reader_key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// One piano key: 2-flop synchronizer followed by a stability counter. The
// stable level flips only after the synchronized input has differed from it
// for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (key treated as released)
//   key_raw    in   raw asynchronous key level, 1 = pressed
//   key_stable out  debounced key level
//   key_change out  high for the cycle in which key_stable is about to flip
// -----------------------------------------------------------------------------
module key_debouncer
  import piano_key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_stable,
  output logic key_change
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flip;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    cnt_d    = '0;
    stable_d = stable_q;
    flip     = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        // The counter already holds DEBOUNCE_CYCLES-1 and this cycle still
        // differs: that makes DEBOUNCE_CYCLES consecutive differing samples.
        flip     = 1'b1;
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the two synchronizer stages a real
      // shift; blocking would collapse them into one flop.
      sync1_q  <= key_raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign key_stable = stable_q;
  assign key_change = flip;

endmodule

// File: rtl/piano_key_reader.sv
// -----------------------------------------------------------------------------
// piano_key_reader
// Debounces 8 piano keys, turns each accepted press/release into an event byte
// and queues it in a small FIFO that the CPU drains through IO reads.
//
// Ports:
//   iCpuClock          in   the only clock
//   iCpuReset          in   asynchronous active-high reset
//   iFpgaKeys[7:0]     in   raw key buttons, 1 = pressed
//   iDoIORead          in   MemOrIO IO-read strobe
//   iDoPianoRead       in   piano-read chip select
//   oPianoReadData     out  {3'b0, overflow, count[3:0], head event[7:0]}
//   oPianoEventPending out  FIFO non-empty
// -----------------------------------------------------------------------------
module piano_key_reader
  import piano_key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // >= 8
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH        // power of two, 2..8
) (
  input  logic                iCpuClock,
  input  logic                iCpuReset,
  input  logic [NUM_KEYS-1:0] iFpgaKeys,
  input  logic                iDoIORead,
  input  logic                iDoPianoRead,
  output logic [15:0]         oPianoReadData,
  output logic                oPianoEventPending
);

  localparam int                 PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] key_stable;
  logic [NUM_KEYS-1:0] key_change;

  key_event_t          fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;

  logic                rd_req;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push_valid;
  logic [KEY_IDX_MSB:0] push_idx;
  logic [NUM_KEYS-1:0] push_onehot;
  key_event_t          push_event;
  key_event_t          head_event;
  logic                do_push;
  logic                do_pop;
  logic                drop;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk       (iCpuClock),
      .rst       (iCpuReset),
      .key_raw   (iFpgaKeys[g]),
      .key_stable(key_stable[g]),
      .key_change(key_change[g])
    );
  end

  // Lowest-index pending key wins; scanning downward lets the lowest overwrite.
  always_comb begin
    push_valid = 1'b0;
    push_idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_valid = 1'b1;
        push_idx   = (KEY_IDX_MSB + 1)'(i);
      end
    end
  end

  always_comb begin
    rd_req      = iDoIORead && iDoPianoRead;
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FULL_COUNT);
    push_onehot = push_valid ? (NUM_KEYS'(1) << push_idx) : '0;
    // The key cannot flip again before its event is pushed, so its current
    // stable level is the direction of that event.
    push_event  = encode_event(push_idx, key_stable[push_idx]);

    do_pop      = rd_req && !fifo_empty;
    // When full, a simultaneous pop frees the slot this push needs.
    do_push     = push_valid && (!fifo_full || do_pop);
    drop        = push_valid && fifo_full && !do_pop;

    pending_d   = (pending_q & ~push_onehot) | key_change;
    wr_ptr_d    = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);

    // Any read clears the sticky flag, even on an empty FIFO.
    if (rd_req) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: storage is not reset; an entry is only visible after it is written,
  // and the read path masks the head to zero while the FIFO is empty.
  always_ff @(posedge iCpuClock) begin
    if (do_push) begin
      fifo_mem_q[wr_ptr_q] <= push_event;
    end
  end

  always_comb begin
    head_event     = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    oPianoReadData = '0;
    oPianoReadData[7:0]                       = head_event;
    oPianoReadData[COUNT_LSB +: COUNT_W]      = count_q;
    oPianoReadData[OVF_BIT]                   = ovf_q;
    oPianoEventPending                        = !fifo_empty;
  end

endmodule

// File: tb/tb_piano_key_reader.sv
// -----------------------------------------------------------------------------
// tb_piano_key_reader
// Directed scenarios followed by random key/read traffic, compared every cycle
// against a behavioural model: a key flips when its last DEBOUNCE_CYCLES
// synchronized samples all differ from its level, events go through a queue.
// -----------------------------------------------------------------------------
module tb_piano_key_reader;

  localparam int DEB   = 16;
  localparam int DEPTH = 8;

  logic        iCpuClock = 1'b0;
  logic        iCpuReset;
  logic [7:0]  iFpgaKeys;
  logic        iDoIORead;
  logic        iDoPianoRead;
  logic [15:0] oPianoReadData;
  logic        oPianoEventPending;

  int n_checks = 0;
  int n_fail   = 0;

  piano_key_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .iCpuClock         (iCpuClock),
    .iCpuReset         (iCpuReset),
    .iFpgaKeys         (iFpgaKeys),
    .iDoIORead         (iDoIORead),
    .iDoPianoRead      (iDoPianoRead),
    .oPianoReadData    (oPianoReadData),
    .oPianoEventPending(oPianoEventPending)
  );

  always #5 iCpuClock = ~iCpuClock;

  // ---------------- reference model ----------------
  bit   [7:0] m_stable;
  bit   [7:0] m_pending;
  bit         m_ovf;
  logic [7:0] m_fifo[$];
  bit   [7:0] m_hist[$];   // raw key samples, oldest first, DEB+2 long

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable  = '0;
    m_pending = '0;
    m_ovf     = 1'b0;
    m_fifo.delete();
    m_hist.delete();
    for (int i = 0; i < DEB + 2; i++) m_hist.push_back(8'h00);
  endtask

  task automatic model_edge(input bit [7:0] raw, input bit rd);
    bit         have;
    int         k;
    logic [7:0] tmp;
    bit         all_diff;
    have = 1'b0;
    k    = 0;
    for (int i = 0; i < 8; i++) begin
      if (!have && m_pending[i]) begin
        have = 1'b1;
        k    = i;
      end
    end
    if (rd) begin
      m_ovf = 1'b0;
      if (m_fifo.size() > 0) tmp = m_fifo.pop_front();
    end
    if (have) begin
      m_pending[k] = 1'b0;
      tmp = {m_stable[k], 4'b0000, 3'(k)};
      if (m_fifo.size() < DEPTH) m_fifo.push_back(tmp);
      else m_ovf = 1'b1;
    end
    // After this push, m_hist[0..DEB-1] are the synchronized samples seen by
    // the last DEB edges (two cycles of synchronizer delay).
    m_hist.push_back(raw);
    tmp = m_hist.pop_front();
    for (int key = 0; key < 8; key++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (m_hist[j][key] == m_stable[key]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_stable[key]  = ~m_stable[key];
        m_pending[key] = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] model_word();
    logic [15:0] w;
    w        = '0;
    w[12]    = m_ovf;
    w[11:8]  = 4'(m_fifo.size());
    if (m_fifo.size() > 0) w[7:0] = m_fifo[0];
    return w;
  endfunction

  // One clock cycle: drive at the negedge, model at the posedge, compare at
  // the following negedge.
  task automatic step(input logic rd_io = 1'b0, input logic rd_cs = 1'b0);
    iDoIORead    = rd_io;
    iDoPianoRead = rd_cs;
    @(posedge iCpuClock);
    model_edge(iFpgaKeys, rd_io && rd_cs);
    @(negedge iCpuClock);
    iDoIORead    = 1'b0;
    iDoPianoRead = 1'b0;
    check("rd_word", {16'h0, oPianoReadData}, {16'h0, model_word()});
    check("evt_pending", {31'h0, oPianoEventPending}, {31'h0, (m_fifo.size() != 0)});
  endtask

  task automatic do_reset(input int cycles);
    iCpuReset = 1'b1;
    #1;
    check("rst_word", {16'h0, oPianoReadData}, 32'h0);
    check("rst_pending", {31'h0, oPianoEventPending}, 32'h0);
    model_reset();
    repeat (cycles) @(posedge iCpuClock);
    @(negedge iCpuClock);
    iCpuReset = 1'b0;
  endtask

  initial begin
    iCpuReset    = 1'b1;
    iFpgaKeys    = 8'h00;
    iDoIORead    = 1'b0;
    iDoPianoRead = 1'b0;
    model_reset();
    repeat (3) @(posedge iCpuClock);
    @(negedge iCpuClock);
    check("reset_word", {16'h0, oPianoReadData}, 32'h0);
    check("reset_pending", {31'h0, oPianoEventPending}, 32'h0);
    iCpuReset = 1'b0;

    // Idle, then a read on an empty FIFO.
    repeat (5) step();
    step(1'b1, 1'b1);
    check("idle_read", {16'h0, oPianoReadData}, 32'h0);

    // Key 3 held for 40 cycles: one event, 2 + DEB + 1 cycles after the edge.
    iFpgaKeys = 8'h08;
    repeat (DEB + 2) step();
    check("k3_not_yet", {16'h0, oPianoReadData}, 32'h0);
    step();
    check("k3_latency", {16'h0, oPianoReadData}, 32'h0183);
    repeat (40 - (DEB + 3)) step();
    check("k3_single", {16'h0, oPianoReadData}, 32'h0183);
    step(1'b1, 1'b1);
    check("k3_after_read", {16'h0, oPianoReadData}, 32'h0);
    iFpgaKeys = 8'h00;
    repeat (DEB + 5) step();
    check("k3_release", {16'h0, oPianoReadData}, 32'h0103);
    step(1'b1, 1'b1);

    // Key 5: 10-cycle glitch is filtered, a long press gives press then release.
    iFpgaKeys = 8'h20;
    repeat (10) step();
    iFpgaKeys = 8'h00;
    repeat (30) step();
    check("k5_glitch", {16'h0, oPianoReadData}, 32'h0);
    iFpgaKeys = 8'h20;
    repeat (20) step();
    iFpgaKeys = 8'h00;
    repeat (DEB + 6) step();
    check("k5_press_head", {16'h0, oPianoReadData}, 32'h0285);
    step(1'b1, 1'b1);
    check("k5_release_head", {16'h0, oPianoReadData}, 32'h0105);
    step(1'b1, 1'b1);
    check("k5_drained", {16'h0, oPianoReadData}, 32'h0);

    // Keys 6 and 1 together: key 1 first, key 6 one cycle later.
    iFpgaKeys = 8'h42;
    repeat (DEB + 3) step();
    check("k61_first", {16'h0, oPianoReadData}, 32'h0181);
    step();
    check("k61_second", {16'h0, oPianoReadData}, 32'h0281);
    step(1'b1, 1'b1);
    check("k61_order", {16'h0, oPianoReadData}, 32'h0186);
    step(1'b1, 1'b1);
    iFpgaKeys = 8'h00;
    repeat (DEB + 5) step();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("k61_drained", {16'h0, oPianoReadData}, 32'h0);

    // Fill, overflow, read clears flag, then push+pop while full.
    iFpgaKeys = 8'hFF;
    repeat (DEB + 12) step();
    check("fill_count", {16'h0, oPianoReadData}, 32'h0880);
    iFpgaKeys = 8'hFE;
    repeat (DEB + 4) step();
    check("ovf_set", {16'h0, oPianoReadData}, 32'h1880);
    step(1'b1, 1'b1);
    check("ovf_cleared", {16'h0, oPianoReadData}, 32'h0781);
    iFpgaKeys = 8'hF8;
    repeat (DEB + 3) step();
    check("refill", {16'h0, oPianoReadData}, 32'h0881);
    step(1'b1, 1'b1);
    check("full_push_pop", {16'h0, oPianoReadData}, 32'h0882);

    // Reset with 3 events buffered and key 4 mid-debounce.
    iFpgaKeys = 8'h00;
    do_reset(3);
    iFpgaKeys = 8'h07;
    repeat (DEB + 5) step();
    check("pre_rst_count", {28'h0, oPianoReadData[11:8]}, 32'h3);
    iFpgaKeys = 8'h17;
    repeat (5) step();
    do_reset(3);
    repeat (DEB + 2) step();
    check("post_rst_quiet", {16'h0, oPianoReadData}, 32'h0);
    step();
    check("post_rst_fresh", {16'h0, oPianoReadData}, 32'h0180);
    repeat (6) step();
    check("post_rst_all", {16'h0, oPianoReadData}, 32'h0480);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) iFpgaKeys ^= 8'(1) << $urandom_range(0, 7);
      if (c == 2000) do_reset(2);
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
